// File: rtl/dstuff_burst_feeder_if.sv
// -----------------------------------------------------------------------------
// dstuff_burst_feeder_if
//
// Purpose:
//   A single ready/valid word stream. The feeder uses one instance on its
//   producer-facing side and one on its blockF-facing side.
//
// Signals:
//   vld   - word valid, driven by the sender
//   rdy   - ready, driven by the receiver
//   data  - DATA_W-bit word, driven by the sender
//
// Modports:
//   master - the sending side (drives vld/data, observes rdy)
//   slave  - the receiving side (observes vld/data, drives rdy)
// -----------------------------------------------------------------------------
interface dstuff_burst_feeder_if #(
  parameter int DATA_W = 32
) ();

  logic              vld;
  logic              rdy;
  logic [DATA_W-1:0] data;

  modport master (
    output vld,
    output data,
    input  rdy
  );

  modport slave (
    input  vld,
    input  data,
    output rdy
  );

endinterface

// File: rtl/dstuff_burst_feeder.sv
// -----------------------------------------------------------------------------
// dstuff_burst_feeder
//
// Purpose:
//   Upstream stage of blockF. Buffers words from a producer in a small FIFO
//   and presents them to blockF's dSin ready/valid input in bursts. Output is
//   held back until BURST words are buffered, a FILL timeout expires, or a
//   flush is requested; the buffer is then drained back-to-back. Words that
//   arrive while draining join the current burst.
//
// Parameters:
//   DATA_W  - word width
//   DEPTH   - FIFO entries (power of 2, >= 2)
//   BURST   - buffered-word threshold that starts a drain (1..DEPTH)
//   TIMEOUT - max cycles spent in FILL before a forced drain (0 = never)
//
// Ports:
//   clk       - clock
//   rst       - asynchronous, active-high reset
//   in_if     - slave stream from the producer (vld/rdy/data)
//   out_if    - master stream toward blockF dSin (vld/rdy/data)
//   flush     - single-cycle request to drain now (only acts in FILL)
//   level     - current buffered word count
//   draining  - high while the feeder is in DRAIN
//   word_cnt  - saturating count of words delivered downstream
//
// Configuration:
//   DSTUFF_FEEDER_STATS_EN - when defined, word_cnt counts pops (saturating at
//   16'hFFFF) and is cleared by reset or by flush while IDLE. When undefined,
//   word_cnt is tied to zero and no counter is built.
// -----------------------------------------------------------------------------
module dstuff_burst_feeder #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  dstuff_burst_feeder_if.slave       in_if,
  dstuff_burst_feeder_if.master      out_if,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       draining,
  output logic [15:0]                word_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Timer just needs to reach TIMEOUT-1; keep at least one bit so the
  // declaration stays legal when the timeout is disabled.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  state_t            state_q,    state_d;
  logic [AW-1:0]     wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]     count_q,    count_d;
  logic [TW-1:0]     timer_q,    timer_d;
  logic              in_rdy_q,   in_rdy_d;
  logic              out_vld_q,  out_vld_d;
  logic              draining_q, draining_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              push;
  logic              pop;
  logic              burst_hit;
  logic              timeout_hit;

  // Handshakes use only registered ready/valid, so there is no combinational
  // path from out_if.rdy to in_if.rdy: a full FIFO refuses a word even on a
  // cycle where it is also popping.
  assign push = in_if.vld && in_rdy_q;
  assign pop  = out_vld_q && out_if.rdy;

  // Next-state logic. The drain decision looks at the post-update count so a
  // word pushed this cycle can complete a burst immediately; because
  // BURST <= DEPTH, a FIFO that becomes full in FILL always starts draining.
  always_comb begin
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    state_d    = state_q;
    timer_d    = timer_q;

    burst_hit   = (count_d >= CW'(BURST));
    timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (push) begin
          state_d = burst_hit ? DRAIN : FILL;
        end
      end
      FILL: begin
        if (timer_q != {TW{1'b1}}) begin
          timer_d = timer_q + TW'(1);
        end
        if (burst_hit || timeout_hit || flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        timer_d = '0;
        if (count_d == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    in_rdy_d   = (count_d < CW'(DEPTH));
    out_vld_d  = (state_d == DRAIN) && (count_d != '0);
    draining_d = (state_d == DRAIN);
  end

  // Control state and registered outputs. in_rdy comes out of reset low and
  // rises on the first clock after release; out_vld falls the moment reset is
  // asserted, so buffered words vanish without an output glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      in_rdy_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      draining_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      in_rdy_q   <= in_rdy_d;
      out_vld_q  <= out_vld_d;
      draining_q <= draining_d;
    end
  end

  // Storage array, deliberately not reset. The head entry is never
  // overwritten while buffered because pushes stop when the FIFO is full.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_if.data;
    end
  end

`ifdef DSTUFF_FEEDER_STATS_EN
  logic [15:0] word_cnt_q, word_cnt_d;

  // Delivered-word counter. A clear from flush can only happen in IDLE,
  // where no pop is possible, so clear and increment never collide.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if ((state_q == IDLE) && flush) begin
      word_cnt_d = '0;
    end else if (pop && (word_cnt_q != 16'hFFFF)) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;
`else
  assign word_cnt = '0;
`endif

  // First-word-fall-through: the head entry is always presented, and it is
  // only qualified by out_vld while draining.
  assign in_if.rdy   = in_rdy_q;
  assign out_if.vld  = out_vld_q;
  assign out_if.data = mem_q[rd_ptr_q];
  assign level       = count_q;
  assign draining    = draining_q;

endmodule

// File: doc/dstuff_burst_feeder.md
Name: dstuff_burst_feeder

Overview:
- Upstream stage of blockF. Buffers words from a producer and drives blockF's dSin ready/valid input.
- Collects words into bursts: output is held until BURST words are buffered, a timeout expires, or a flush is requested. The buffer then drains back-to-back.
- Reduces fragmented traffic into blockF.
- Exposes fill level and state for status/debug.

Parameters:
- DATA_W, 32, width of data words.
- DEPTH, 8, FIFO entries; power of 2, >=2.
- BURST, 4, buffered-word threshold that starts a drain; 1..DEPTH.
- TIMEOUT, 16, max cycles spent in FILL before a forced drain; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_vld  in  1  upstream word valid.
- in_rdy  out  1  upstream ready.
- in_data  in  DATA_W  upstream word.
- out_vld  out  1  valid toward blockF dSin.
- out_rdy  in  1  ready from blockF dSin.
- out_data  out  DATA_W  word toward blockF dSin.
- flush  in  1  single-cycle request to drain now.
- level  out  $clog2(DEPTH)+1  current buffered word count.
- draining  out  1  high while in DRAIN.
- word_cnt  out  16  words delivered downstream (see Optional Feature).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - wr_ptr, rd_ptr, count, timer = 0; state = IDLE.
  - out_vld = 0, draining = 0, level = 0, word_cnt = 0.
  - in_rdy = 0 while rst is high, 1 on the first cycle after release.
  - FIFO storage is not reset.
- Reset mid-operation discards all buffered words with no output glitch; out_vld drops asynchronously.
- Push = in_vld && in_rdy. Pop = out_vld && out_rdy.
- in_rdy = (count < DEPTH), from registered count only. No combinational path from out_rdy, so a full FIFO does not accept even if a pop occurs in the same cycle.
- out_vld = (state == DRAIN) && (count > 0). out_data is first-word-fall-through of the head entry, stable while out_vld && !out_rdy.
- count_next = count + push - pop. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Latency: a word pushed at cycle t is visible on out_data no earlier than t+1, and only in DRAIN.
- State machine:
  - IDLE (count == 0):
    - push -> FILL, timer = 0.
    - flush ignored.
  - FILL:
    - timer increments each cycle, saturating.
    - -> DRAIN when any of: count_next >= BURST; (TIMEOUT != 0 && timer == TIMEOUT-1); flush.
  - DRAIN:
    - pops allowed; pushes continue and are drained in the same burst.
    - -> IDLE when count_next == 0.
    - flush is a no-op.
- BURST == 1: the first push moves directly to DRAIN.
- count_next == DEPTH in FILL always satisfies the BURST condition, so a full buffer always drains.
- draining = (state == DRAIN). level = count.

Optional Feature:
- Macro: DSTUFF_FEEDER_STATS_EN.
- Defined:
  - word_cnt increments on every pop and saturates at 16'hFFFF.
  - word_cnt clears on reset and when flush is asserted in IDLE.
- Undefined:
  - word_cnt is tied to 0 and no counter logic is synthesised.
  - All other behaviour is identical.

Test Plan (DEPTH=8, BURST=4, TIMEOUT=16):
- Push 4 words A0..A3 on consecutive cycles, out_rdy = 1 -> out_vld first rises the cycle after A3's push; A0..A3 emerge on 4 consecutive cycles; then draining = 0 and level = 0.
- Push 2 words, then idle -> out_vld stays 0 for 16 cycles in FILL, then DRAIN; 2 words emerge; state returns to IDLE.
- Push 1 word, flush pulse 3 cycles later -> DRAIN next cycle; word delivered; flush in IDLE has no effect.
- out_rdy = 0, push 10 words -> 8 accepted, in_rdy = 0 at level = 8, out_data holds word 0. Raise out_rdy -> 8 words delivered in order; the 2 stalled words then accepted.
- During DRAIN, push and pop on the same cycle with count = 3 -> level stays 3; FIFO order preserved across pointer wrap (at least 20 words streamed).
- Assert rst mid-DRAIN with level = 5 -> out_vld = 0 immediately, level = 0. After release, a 4-word burst works normally. With STATS_EN defined, word_cnt = 0 after reset.
